// File: rtl/fp_pkg.sv
// Shared types and helpers for the FP special-operand resolver.
// Operand classes, operation encodings and the canonical quiet NaN pattern.
package fp_pkg;

    typedef enum logic [2:0] {
        FP_ZERO = 3'd0,
        FP_SUB  = 3'd1,
        FP_NORM = 3'd2,
        FP_INF  = 3'd3,
        FP_QNAN = 3'd4,
        FP_SNAN = 3'd5
    } fp_class_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } fp_op_e;

    localparam int FP_MAX_W = 64;

    // Sign 0, exponent all ones, fraction MSB set; caller slices to its width.
    function automatic logic [FP_MAX_W-1:0] canonical_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] q;
        q = '0;
        for (int i = 0; i < FP_MAX_W; i++) begin
            if (i >= man_w - 1 && i < man_w + exp_w) begin
                q[i] = 1'b1;
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: splits an IEEE-754 operand into its class.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int DAZ   = 0,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] operand,
    output fp_class_e    op_class
);

    logic [EXP_W-1:0] exp_field;
    logic [MAN_W-1:0] frac_field;

    assign exp_field  = operand[W-2:MAN_W];
    assign frac_field = operand[MAN_W-1:0];

    always_comb begin
        op_class = FP_NORM;
        if (exp_field == '1) begin
            if (frac_field == '0) begin
                op_class = FP_INF;
            end else if (frac_field[MAN_W-1]) begin
                op_class = FP_QNAN;
            end else begin
                op_class = FP_SNAN;
            end
        end else if (exp_field == '0) begin
            // Flushed subnormals behave as signed zeros everywhere downstream.
            if (frac_field == '0 || DAZ != 0) begin
                op_class = FP_ZERO;
            end else begin
                op_class = FP_SUB;
            end
        end
    end

endmodule

// File: rtl/fp_special_case_unit.sv
// Two-stage special-operand resolver for FP add/sub/mul: classifies operands,
// produces the bypass result when special cases decide it, and keeps a sticky invalid flag.
module fp_special_case_unit
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int DAZ   = 0,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic         rm_down,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         special,
    output logic [W-1:0] special_result,
    output logic [2:0]   a_class,
    output logic [2:0]   b_class,
    output logic         invalid,
    input  logic         clr_flags,
    output logic         flag_invalid
);

    localparam logic [FP_MAX_W-1:0] QNAN_FULL = canonical_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]        QNAN      = QNAN_FULL[W-1:0];
    localparam logic [W-2:0]        INF_MAG   = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    fp_class_e a_cls, b_cls;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DAZ(DAZ)) u_class_a (.operand(a), .op_class(a_cls));
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DAZ(DAZ)) u_class_b (.operand(b), .op_class(b_cls));

    logic         s1_valid, s2_valid;
    logic         s2_advance, s1_advance;
    fp_class_e    s1_a_class, s1_b_class;
    fp_op_e       s1_op;
    logic         s1_rm_down;
    logic [W-1:0] s1_a, s1_b;

    logic         s2_special, s2_invalid, s2_flag;
    logic [W-1:0] s2_result;
    fp_class_e    s2_a_class, s2_b_class;

    assign s2_advance = !s2_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;

    logic         res_special, res_invalid;
    logic [W-1:0] res_result;
    logic         a_sign, sb_eff, mul_sign;
    logic         a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

    always_comb begin
        a_sign   = s1_a[W-1];
        sb_eff   = s1_b[W-1] ^ (s1_op == OP_SUB);
        mul_sign = s1_a[W-1] ^ s1_b[W-1];
        a_snan   = (s1_a_class == FP_SNAN);
        b_snan   = (s1_b_class == FP_SNAN);
        a_nan    = a_snan || (s1_a_class == FP_QNAN);
        b_nan    = b_snan || (s1_b_class == FP_QNAN);
        a_inf    = (s1_a_class == FP_INF);
        b_inf    = (s1_b_class == FP_INF);
        a_zero   = (s1_a_class == FP_ZERO);
        b_zero   = (s1_b_class == FP_ZERO);

        res_special = 1'b1;
        res_invalid = 1'b0;
        res_result  = '0;

        if (a_nan || b_nan || s1_op == OP_RSVD) begin
            res_result  = QNAN;
            res_invalid = a_snan || b_snan || (s1_op == OP_RSVD);
        end else if (s1_op != OP_MUL) begin
            if (a_inf && b_inf && a_sign != sb_eff) begin
                res_result  = QNAN;
                res_invalid = 1'b1;
            end else if (a_inf) begin
                res_result = {a_sign, INF_MAG};
            end else if (b_inf) begin
                res_result = {sb_eff, INF_MAG};
            end else if (a_zero && b_zero) begin
                // Opposite-signed zeros sum to +0 except when rounding toward negative.
                res_result = {(a_sign == sb_eff) ? a_sign : s1_rm_down, {(W-1){1'b0}}};
            end else if (a_zero) begin
                res_result = {sb_eff, s1_b[W-2:0]};
            end else if (b_zero) begin
                res_result = s1_a;
            end else begin
                res_special = 1'b0;
            end
        end else begin
            if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                res_result  = QNAN;
                res_invalid = 1'b1;
            end else if (a_inf || b_inf) begin
                res_result = {mul_sign, INF_MAG};
            end else if (a_zero || b_zero) begin
                res_result = {mul_sign, {(W-1){1'b0}}};
            end else begin
                res_special = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a_class <= FP_ZERO;
            s1_b_class <= FP_ZERO;
            s1_op      <= OP_ADD;
            s1_rm_down <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
        end else if (s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a_class <= a_cls;
                s1_b_class <= b_cls;
                s1_op      <= fp_op_e'(op);
                s1_rm_down <= rm_down;
                s1_a       <= a;
                s1_b       <= b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_special <= 1'b0;
            s2_result  <= '0;
            s2_invalid <= 1'b0;
            s2_a_class <= FP_ZERO;
            s2_b_class <= FP_ZERO;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_special <= res_special;
                s2_result  <= res_result;
                s2_invalid <= res_invalid;
                s2_a_class <= s1_a_class;
                s2_b_class <= s1_b_class;
            end
        end
    end

    // A transfer that raises invalid takes precedence over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_flag <= 1'b0;
        end else if (s2_valid && out_ready && s2_invalid) begin
            s2_flag <= 1'b1;
        end else if (clr_flags) begin
            s2_flag <= 1'b0;
        end
    end

    assign out_valid      = s2_valid;
    assign special        = s2_special;
    assign special_result = s2_result;
    assign invalid        = s2_invalid;
    assign a_class        = s2_a_class;
    assign b_class        = s2_b_class;
    assign flag_invalid   = s2_flag;

endmodule

// File: tb/tb_fp_special_case_unit.sv
// Directed bench for fp_special_case_unit: binary32 (DAZ off/on) and binary16 instances,
// table-driven single transactions plus stream, sticky-flag and reset sequences.
module tb_fp_special_case_unit;

    logic        clk, rst_n;
    logic        in_valid, out_ready, rm_down, clr_flags;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [15:0] a_h, b_h;

    logic        in_ready, out_valid, special, invalid, flag_invalid;
    logic [31:0] special_result;
    logic [2:0]  a_class, b_class;

    logic        d_in_ready, d_out_valid, d_special, d_invalid, d_flag_invalid;
    logic [31:0] d_special_result;
    logic [2:0]  d_a_class, d_b_class;

    logic        h_in_ready, h_out_valid, h_special, h_invalid, h_flag_invalid;
    logic [15:0] h_special_result;
    logic [2:0]  h_a_class, h_b_class;

    int total = 0;
    int bad   = 0;

    fp_special_case_unit #(.EXP_W(8), .MAN_W(23), .DAZ(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rm_down(rm_down), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .special(special), .special_result(special_result), .a_class(a_class),
        .b_class(b_class), .invalid(invalid), .clr_flags(clr_flags), .flag_invalid(flag_invalid)
    );

    fp_special_case_unit #(.EXP_W(8), .MAN_W(23), .DAZ(1)) dut_daz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready), .op(op),
        .rm_down(rm_down), .a(a), .b(b), .out_valid(d_out_valid), .out_ready(out_ready),
        .special(d_special), .special_result(d_special_result), .a_class(d_a_class),
        .b_class(d_b_class), .invalid(d_invalid), .clr_flags(clr_flags), .flag_invalid(d_flag_invalid)
    );

    fp_special_case_unit #(.EXP_W(5), .MAN_W(10), .DAZ(0)) dut_half (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready), .op(op),
        .rm_down(rm_down), .a(a_h), .b(b_h), .out_valid(h_out_valid), .out_ready(out_ready),
        .special(h_special), .special_result(h_special_result), .a_class(h_a_class),
        .b_class(h_b_class), .invalid(h_invalid), .clr_flags(clr_flags), .flag_invalid(h_flag_invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        rm;
        logic [31:0] a;
        logic [31:0] b;
        logic        sp;
        logic [31:0] res;
        logic        inv;
        logic [2:0]  ac;
        logic [2:0]  bc;
        logic [31:0] d_res;
        logic        d_inv;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        op = v.op; rm_down = v.rm; a = v.a; b = v.b;
        in_valid = 1'b1;
        check_output($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_output($sformatf("v%0d_early_valid", idx), {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check_output($sformatf("v%0d_out_valid", idx), {31'd0, out_valid}, 32'd1);
        check_output($sformatf("v%0d_special", idx), {31'd0, special}, {31'd0, v.sp});
        check_output($sformatf("v%0d_result", idx), special_result, v.res);
        check_output($sformatf("v%0d_invalid", idx), {31'd0, invalid}, {31'd0, v.inv});
        check_output($sformatf("v%0d_a_class", idx), {29'd0, a_class}, {29'd0, v.ac});
        check_output($sformatf("v%0d_b_class", idx), {29'd0, b_class}, {29'd0, v.bc});
        check_output($sformatf("v%0d_daz_result", idx), d_special_result, v.d_res);
        check_output($sformatf("v%0d_daz_invalid", idx), {31'd0, d_invalid}, {31'd0, v.d_inv});
        @(posedge clk); #1;
        check_output($sformatf("v%0d_flag", idx), {31'd0, flag_invalid}, {31'd0, v.inv});
        check_output($sformatf("v%0d_drained", idx), {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_stream();
        int sent = 0;
        int recv = 0;
        logic stall_seen = 1'b0;
        logic hold_pending = 1'b0;
        logic [31:0] held = '0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 6);
            op = 2'b00; rm_down = 1'b0; a = 32'h0; b = 32'h40000000 + sent;
            @(negedge clk);
            if (hold_pending) begin
                check_output("stream_hold_valid", {31'd0, out_valid}, 32'd1);
                check_output("stream_hold_data", special_result, held);
                hold_pending = 1'b0;
            end
            if (in_valid && !in_ready) stall_seen = 1'b1;
            if (out_valid && out_ready) begin
                check_output($sformatf("stream_data%0d", recv), special_result, 32'h40000000 + recv);
                recv++;
            end else if (out_valid) begin
                held = special_result;
                hold_pending = 1'b1;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_output("stream_count", recv, 32'd6);
        check_output("stream_stall_seen", {31'd0, stall_seen}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_output("stream_no_extra", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1, 3'd3, 3'd3, 32'h7FC00000, 1'b1};
        vecs[1]  = '{2'b00, 1'b0, 32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 1'b1, 3'd5, 3'd2, 32'h7FC00000, 1'b1};
        vecs[2]  = '{2'b00, 1'b0, 32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 1'b0, 3'd4, 3'd2, 32'h7FC00000, 1'b0};
        vecs[3]  = '{2'b00, 1'b0, 32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 3'd0, 3'd0, 32'h00000000, 1'b0};
        vecs[4]  = '{2'b00, 1'b1, 32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 3'd0, 3'd0, 32'h80000000, 1'b0};
        vecs[5]  = '{2'b01, 1'b0, 32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 1'b0, 3'd0, 3'd2, 32'hC0000000, 1'b0};
        vecs[6]  = '{2'b10, 1'b0, 32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 1'b0, 3'd3, 3'd2, 32'hFF800000, 1'b0};
        vecs[7]  = '{2'b10, 1'b0, 32'h7F800000, 32'h80000000, 1'b1, 32'h7FC00000, 1'b1, 3'd3, 3'd0, 32'h7FC00000, 1'b1};
        vecs[8]  = '{2'b10, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h00000000, 1'b0, 3'd2, 3'd2, 32'h00000000, 1'b0};
        vecs[9]  = '{2'b10, 1'b0, 32'h00000001, 32'h7F800000, 1'b1, 32'h7F800000, 1'b0, 3'd1, 3'd3, 32'h7FC00000, 1'b1};
        vecs[10] = '{2'b11, 1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h7FC00000, 1'b1, 3'd2, 3'd2, 32'h7FC00000, 1'b1};
        vecs[11] = '{2'b00, 1'b0, 32'h3F800000, 32'hFF800000, 1'b1, 32'hFF800000, 1'b0, 3'd2, 3'd3, 32'hFF800000, 1'b0};
        vecs[12] = '{2'b00, 1'b0, 32'h40000000, 32'h00000000, 1'b1, 32'h40000000, 1'b0, 3'd2, 3'd0, 32'h40000000, 1'b0};
        vecs[13] = '{2'b01, 1'b0, 32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 3'd3, 3'd3, 32'hFF800000, 1'b0};
        vecs[14] = '{2'b00, 1'b0, 32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 3'd0, 3'd0, 32'h80000000, 1'b0};
        vecs[15] = '{2'b10, 1'b0, 32'h80000000, 32'hFF800000, 1'b1, 32'h7FC00000, 1'b1, 3'd0, 3'd3, 32'h7FC00000, 1'b1};
        vecs[16] = '{2'b00, 1'b0, 32'h00000000, 32'h80000001, 1'b1, 32'h80000001, 1'b0, 3'd0, 3'd1, 32'h00000000, 1'b0};

        clk = 1'b0; rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; rm_down = 1'b0; clr_flags = 1'b0;
        op = 2'b00; a = '0; b = '0; a_h = '0; b_h = '0;

        #12;
        check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("rst_special", {31'd0, special}, 32'd0);
        check_output("rst_result", special_result, 32'd0);
        check_output("rst_classes", {26'd0, a_class, b_class}, 32'd0);
        check_output("rst_invalid_flag", {30'd0, invalid, flag_invalid}, 32'd0);
        check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] table vectors");
        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(i);
        end

        $display("[TB] half-precision inf minus inf");
        op = 2'b01; a_h = 16'h7C00; b_h = 16'h7C00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_output("half_valid", {31'd0, h_out_valid}, 32'd1);
        check_output("half_result", {16'd0, h_special_result}, 32'h00007E00);
        check_output("half_invalid", {31'd0, h_invalid}, 32'd1);
        a_h = '0; b_h = '0;
        @(posedge clk); #1;

        $display("[TB] sticky flag set beats clear");
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        check_output("flag_cleared", {31'd0, flag_invalid}, 32'd0);
        op = 2'b00; a = 32'h7F800001; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_output("flag_pre_transfer", {31'd0, flag_invalid}, 32'd0);
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        check_output("flag_set_wins", {31'd0, flag_invalid}, 32'd1);
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        check_output("flag_clear_after", {31'd0, flag_invalid}, 32'd0);

        $display("[TB] stream with backpressure");
        run_stream();

        $display("[TB] reset mid-stream");
        op = 2'b11; a = 32'h3F800000; b = 32'h3F800000; out_ready = 1'b1; in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_output("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check_output("pre_rst_flag", {31'd0, flag_invalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_output("mid_rst_flag", {31'd0, flag_invalid}, 32'd0);
        check_output("mid_rst_result", {31'd0, special}, 32'd0);
        check_output("mid_rst_data", special_result, 32'd0);
        check_output("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("post_rst_idle", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_special_case_unit.md
# fp_special_case_unit

Parametrised, pipelined IEEE-754 special-operand resolver for the FP add/sub/mul datapath. It classifies both operands, decides whether the result is fully determined by special cases (NaN, Inf, zero, invalid combinations), and emits the bypass result with a sticky invalid flag. It sits beside the mantissa/exponent datapath. The datapath result muxer uses `special` to select `special_result` over the arithmetic result. Operand format, operation set, subnormal treatment and flow control are all generalised.

## Interface
- `EXP_W`, 8, exponent width
- `MAN_W`, 23, stored fraction width (no hidden bit); operand width `W = 1+EXP_W+MAN_W`
- `DAZ`, 0, 1 = subnormal inputs treated as zero of same sign

Ports:
- `clk` in 1, single clock
- `rst_n` in 1, asynchronous, active-low reset
- `in_valid` in 1 / `in_ready` out 1, input handshake
- `op` in 2, 00 add, 01 sub, 10 mul, 11 reserved
- `rm_down` in 1, rounding mode is round-toward-negative (zero-sign rule only)
- `a`, `b` in W, operands
- `out_valid` out 1 / `out_ready` in 1, output handshake
- `special` out 1, result fully determined here
- `special_result` out W, bypass result (0 when `special`=0)
- `a_class`, `b_class` out 3, operand classes
- `invalid` out 1, this result raises invalid
- `clr_flags` in 1, synchronous clear of sticky flag
- `flag_invalid` out 1, sticky invalid

## Operation
- Classes: ZERO, SUB, NORM, INF, QNAN (fraction MSB 1), SNAN (exp all-ones, fraction MSB 0, nonzero). SUB becomes ZERO when `DAZ`=1.
- Canonical qNaN: sign 0, exp all-ones, fraction MSB 1, rest 0. Payloads are never propagated.
- Priority, first match wins:
  - Any NaN, or `op`=11 → qNaN. `invalid` = any SNAN or `op`=11.
  - add/sub: `sb' = b.sign ^ (op==sub)`.
    - INF and INF with `a.sign != sb'` → qNaN, invalid.
    - Any INF → Inf with sign of the infinite operand (`sb'` for b).
    - ZERO+ZERO → zero; sign = `a.sign` if `a.sign==sb'`, else `rm_down`.
    - One ZERO → other operand; b's sign is replaced by `sb'`.
    - ZERO is the `DAZ`-flushed class when applicable.
  - mul: sign = `a.sign ^ b.sign`.
    - INF×ZERO → qNaN, invalid.
    - Any INF → Inf.
    - Any ZERO → zero.
  - Otherwise `special`=0.
- Sticky flag:
  - `flag_invalid` sets when an `invalid` result is transferred (`out_valid && out_ready`).
  - `clr_flags` clears it.
  - If a set and `clr_flags` occur in the same cycle, the set wins.

## Timing
- Two-stage pipeline:
  - S1 registers operand classes, signs and op.
  - S2 registers resolved outputs.
- Latency 2 cycles from input transfer to `out_valid`. Throughput 1/cycle.
- S2 advances when `!s2_valid || out_ready`. S1 advances when `!s1_valid || s2_advance`.
- `in_ready = !s1_valid || s2_advance`. This is combinational from `out_ready`, and is the only combinational in→out path.
- Outputs hold stable while `out_valid && !out_ready`. No loss, duplication or reordering.
- Reset (any time, including mid-stream) drops in-flight data. All outputs go to 0: valids, `special`, `special_result`, classes = ZERO encoding 0, `invalid`, `flag_invalid`.
- `in_ready` = 1 after reset.

## Structure
- Package `fp_pkg`:
  - class enum (ZERO=0, SUB=1, NORM=2, INF=3, QNAN=4, SNAN=5)
  - op encodings
  - canonical-qNaN function parametrised by `EXP_W`/`MAN_W`
- Sub-module `fp_classify`: combinational, one instance per operand, feeding S1.
- Resolution logic and handshake live in the top.

## Test plan
- binary32: `7F800000` sub `7F800000` → after 2 cycles `special`=1, `special_result`=`7FC00000`, `invalid`=1, `flag_invalid`=1.
- `7F800001` add `3F800000` → `7FC00000`, invalid=1. `7FC00001` add `3F800000` → `7FC00000`, invalid=0. Then `clr_flags` with a simultaneous invalid transfer → flag stays 1.
- `00000000` add `80000000`: `rm_down`=0 → `00000000`; `rm_down`=1 → `80000000`. `00000000` sub `40000000` → `C0000000`.
- mul `FF800000`×`40000000` → `FF800000`. `7F800000`×`80000000` → `7FC00000` invalid. `3F800000`×`40000000` → `special`=0.
- `DAZ`=1: `00000001`×`7F800000` → `7FC00000` invalid. `DAZ`=0: → `7F800000`, `a_class`=SUB. Half (`EXP_W`=5, `MAN_W`=10): `7C00` sub `7C00` → `7E00`.
- Stream 6 ops, `out_ready` low cycles 3-5: `in_ready` drops once S1/S2 full, and outputs emerge in order with no drop or duplication. Assert `rst_n` mid-stream → `out_valid`=0 and `flag_invalid`=0 immediately.
